// File: rtl/lector_rgb_if.sv
// Keypad, motor-timer and color-output signals of the RGB keypad reader.
interface lector_rgb_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       flag_R;
    logic       flag_G;
    logic       flag_B;
    logic [4:0] R;
    logic [4:0] G;
    logic [4:0] B;
    logic       enter;
    logic       motor_R;
    logic       motor_G;
    logic       motor_B;
    logic       busy;
    logic       err;

    modport master (
        output key_valid, key_code, flag_R, flag_G, flag_B,
        input  R, G, B, enter, motor_R, motor_G, motor_B, busy, err
    );

    modport slave (
        input  key_valid, key_code, flag_R, flag_G, flag_B,
        output R, G, B, enter, motor_R, motor_G, motor_B, busy, err
    );
endinterface

// File: rtl/lector_rgb.sv
// Keypad reader for an RGB dispenser: collects three amounts (0-15) digit by
// digit, then enables the motors until the timer flags report each color done.
module lector_rgb #(
    parameter logic [3:0] KEY_OK     = 4'hA,
    parameter logic [3:0] KEY_CANCEL = 4'hB,
    parameter logic [3:0] KEY_START  = 4'hE
) (
    input logic         clk,
    input logic         rst,
    lector_rgb_if.slave bus
);
    // state  | meaning
    // READ_R | collecting digits for red
    // READ_G | collecting digits for green
    // READ_B | collecting digits for blue
    // READY  | all three amounts confirmed, waiting for start
    // RUN    | motors dispensing until every enable has dropped
    typedef enum logic [2:0] {
        READ_R = 3'd0,
        READ_G = 3'd1,
        READ_B = 3'd2,
        READY  = 3'd3,
        RUN    = 3'd4
    } state_t;

    localparam logic [4:0] NOT_SET = 5'd16;

    state_t     state_q, state_d;
    logic [4:0] acc_q, acc_d;
    logic [1:0] ndig_q, ndig_d;
    logic [4:0] r_q, r_d;
    logic [4:0] g_q, g_d;
    logic [4:0] b_q, b_d;
    logic [2:0] motor_q, motor_d;
    logic       enter_q, enter_d;
    logic       err_q, err_d;

    logic       restart;
    logic       key_digit;
    logic [7:0] cand;
    logic [2:0] flags;

    assign flags     = {bus.flag_R, bus.flag_G, bus.flag_B};
    assign key_digit = (bus.key_code <= 4'd9);
    assign cand      = ({3'b000, acc_q} * 8'd10) + {4'b0000, bus.key_code};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= READ_R;
            acc_q   <= 5'd0;
            ndig_q  <= 2'd0;
            r_q     <= NOT_SET;
            g_q     <= NOT_SET;
            b_q     <= NOT_SET;
            motor_q <= 3'b000;
            enter_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ndig_q  <= ndig_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            motor_q <= motor_d;
            enter_q <= enter_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ndig_d  = ndig_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        motor_d = motor_q;
        enter_d = 1'b0;
        err_d   = 1'b0;
        restart = 1'b0;

        unique case (state_q)
            READ_R, READ_G, READ_B: begin
                if (bus.key_valid) begin
                    if (key_digit) begin
                        if ((cand <= 8'd15) && (ndig_q < 2'd2)) begin
                            acc_d  = cand[4:0];
                            ndig_d = ndig_q + 2'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.key_code == KEY_OK) begin
                        if (ndig_q == 2'd0) begin
                            err_d = 1'b1;
                        end else begin
                            acc_d  = 5'd0;
                            ndig_d = 2'd0;
                            case (state_q)
                                READ_R: begin
                                    r_d     = acc_q;
                                    state_d = READ_G;
                                end
                                READ_G: begin
                                    g_d     = acc_q;
                                    state_d = READ_B;
                                end
                                default: begin
                                    b_d     = acc_q;
                                    state_d = READY;
                                end
                            endcase
                        end
                    end else if (bus.key_code == KEY_CANCEL) begin
                        restart = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READY: begin
                if (bus.key_valid) begin
                    if (bus.key_code == KEY_START) begin
                        enter_d = 1'b1;
                        state_d = RUN;
                        motor_d = {r_q != 5'd0, g_q != 5'd0, b_q != 5'd0};
                    end else if (bus.key_code == KEY_CANCEL) begin
                        restart = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                err_d = bus.key_valid;
                // The timer has just been started while enter is high, so its
                // flags are still stale in that cycle.
                if (motor_q == 3'b000) begin
                    restart = 1'b1;
                end else if (!enter_q) begin
                    motor_d = motor_q & ~flags;
                end
            end
            default: begin
                restart = 1'b1;
            end
        endcase

        if (restart) begin
            state_d = READ_R;
            acc_d   = 5'd0;
            ndig_d  = 2'd0;
            r_d     = NOT_SET;
            g_d     = NOT_SET;
            b_d     = NOT_SET;
        end
    end

    always_comb begin
        bus.R       = r_q;
        bus.G       = g_q;
        bus.B       = b_q;
        bus.motor_R = motor_q[2];
        bus.motor_G = motor_q[1];
        bus.motor_B = motor_q[0];
        bus.enter   = enter_q;
        bus.busy    = (state_q == RUN);
        bus.err     = err_q;
    end
endmodule

// File: tb/tb_lector_rgb.sv
// Self-checking bench for lector_rgb: directed scenarios plus a randomized
// key/flag stream compared against a behavioural model of the dispenser.
module tb_lector_rgb;
    localparam logic [3:0] K_OK  = 4'hA;
    localparam logic [3:0] K_CAN = 4'hB;
    localparam logic [3:0] K_ST  = 4'hE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lector_rgb_if bus();

    lector_rgb #(.KEY_OK(K_OK), .KEY_CANCEL(K_CAN), .KEY_START(K_ST)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Observable outputs packed as {R, G, B, motors RGB, enter, busy, err}
    function automatic logic [20:0] snap();
        return {bus.R, bus.G, bus.B, bus.motor_R, bus.motor_G, bus.motor_B,
                bus.enter, bus.busy, bus.err};
    endfunction

    function automatic logic [20:0] pack(int r, int g, int b, logic [2:0] m,
                                         logic en, logic bz, logic er);
        return {5'(r), 5'(g), 5'(b), m, en, bz, er};
    endfunction

    task automatic cyc(logic kv, logic [3:0] code, logic [2:0] fl);
        bus.key_valid = kv;
        bus.key_code  = code;
        {bus.flag_R, bus.flag_G, bus.flag_B} = fl;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        {bus.flag_R, bus.flag_G, bus.flag_B} = 3'b000;
    endtask

    task automatic key(logic [3:0] code);
        cyc(1'b1, code, 3'b000);
    endtask

    // ---------------- behavioural model ----------------
    int m_phase;           // 0..2 = reading color index, 3 = ready, 4 = running
    int m_vals[3];
    int m_acc, m_ndig;
    bit m_mot[3];
    bit m_enter, m_err;

    task automatic model_clear();
        m_phase = 0;
        for (int i = 0; i < 3; i++) begin
            m_vals[i] = 16;
            m_mot[i]  = 1'b0;
        end
        m_acc = 0; m_ndig = 0; m_enter = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(bit kv, logic [3:0] code, logic [2:0] fl);
        bit just_started;
        int c;
        just_started = m_enter;
        m_enter = 1'b0;
        m_err   = 1'b0;
        if (m_phase == 4) begin
            if (kv) m_err = 1'b1;
            if (!m_mot[0] && !m_mot[1] && !m_mot[2]) begin
                m_phase = 0;
                for (int i = 0; i < 3; i++) m_vals[i] = 16;
            end else if (!just_started) begin
                for (int i = 0; i < 3; i++) if (fl[2-i]) m_mot[i] = 1'b0;
            end
        end else if (kv) begin
            if (code == K_CAN) begin
                m_phase = 0; m_acc = 0; m_ndig = 0;
                for (int i = 0; i < 3; i++) m_vals[i] = 16;
            end else if (m_phase == 3) begin
                if (code == K_ST) begin
                    m_enter = 1'b1;
                    m_phase = 4;
                    for (int i = 0; i < 3; i++) m_mot[i] = (m_vals[i] != 0);
                end else m_err = 1'b1;
            end else if (code <= 9) begin
                c = m_acc * 10 + int'(code);
                if (c <= 15 && m_ndig < 2) begin
                    m_acc = c; m_ndig++;
                end else m_err = 1'b1;
            end else if (code == K_OK) begin
                if (m_ndig == 0) m_err = 1'b1;
                else begin
                    m_vals[m_phase] = m_acc;
                    m_acc = 0; m_ndig = 0; m_phase++;
                end
            end else m_err = 1'b1;
        end
    endtask

    function automatic logic [20:0] model_out();
        return pack(m_vals[0], m_vals[1], m_vals[2], {m_mot[0], m_mot[1], m_mot[2]},
                    m_enter, m_phase == 4, m_err);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [20:0] e;
        rst = 1'b1;
        @(posedge clk);
        #1;
        e = pack(16, 16, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL reset_state got %h exp %h", snap(), e); end
        rst = 1'b0;
    endtask

    task automatic test_dispense();
        logic [20:0] e;
        key(4'd1); key(4'd2); key(K_OK); key(4'd7); key(K_OK); key(4'd1); key(4'd5);
        e = pack(12, 7, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL b_held_16 got %h exp %h", snap(), e); end
        key(K_OK);
        key(K_ST);
        e = pack(12, 7, 15, 3'b111, 1, 1, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL start_pulse got %h exp %h", snap(), e); end
        cyc(1'b0, 4'd0, 3'b100);
        e = pack(12, 7, 15, 3'b111, 0, 1, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL flag_in_enter_cycle got %h exp %h", snap(), e); end
        cyc(1'b1, K_OK, 3'b010);
        e = pack(12, 7, 15, 3'b101, 0, 1, 1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL flag_g_key_in_run got %h exp %h", snap(), e); end
        cyc(1'b0, 4'd0, 3'b101);
        e = pack(12, 7, 15, 3'b000, 0, 1, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL flags_rb_together got %h exp %h", snap(), e); end
        cyc(1'b0, 4'd0, 3'b000);
        e = pack(16, 16, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL run_done got %h exp %h", snap(), e); end
    endtask

    task automatic test_digit_limits();
        logic [20:0] e;
        key(4'd2); key(K_OK); key(4'd1);
        key(4'd6);
        e = pack(2, 16, 16, 3'b000, 0, 0, 1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL over_15 got %h exp %h", snap(), e); end
        key(4'd1);
        e = pack(2, 16, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL second_digit got %h exp %h", snap(), e); end
        key(4'd5);
        e = pack(2, 16, 16, 3'b000, 0, 0, 1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL third_digit got %h exp %h", snap(), e); end
        key(K_OK);
        e = pack(2, 11, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL acc_kept got %h exp %h", snap(), e); end
        key(K_CAN);
    endtask

    task automatic test_ok_cancel();
        logic [20:0] e;
        key(K_OK);
        e = pack(16, 16, 16, 3'b000, 0, 0, 1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL ok_no_digit got %h exp %h", snap(), e); end
        key(4'hC);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL code_c got %h exp %h", snap(), e); end
        key(4'd3); key(K_OK);
        e = pack(3, 16, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL r_is_3 got %h exp %h", snap(), e); end
        key(K_CAN);
        e = pack(16, 16, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL cancel got %h exp %h", snap(), e); end
        key(4'd4); key(K_OK);
        e = pack(4, 16, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL back_in_read_r got %h exp %h", snap(), e); end
        key(K_CAN);
    endtask

    task automatic test_all_zero();
        logic [20:0] e;
        key(4'd0); key(4'd0); key(K_OK); key(4'd0); key(K_OK); key(4'd0); key(K_OK);
        key(4'd7);
        e = pack(0, 0, 0, 3'b000, 0, 0, 1);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL ready_digit got %h exp %h", snap(), e); end
        key(K_ST);
        e = pack(0, 0, 0, 3'b000, 1, 1, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL zero_start got %h exp %h", snap(), e); end
        cyc(1'b0, 4'd0, 3'b000);
        e = pack(16, 16, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL zero_run_one_cycle got %h exp %h", snap(), e); end
    endtask

    task automatic test_async_reset();
        logic [20:0] e;
        key(4'd1); key(K_OK); key(4'd1); key(K_OK); key(4'd1); key(K_OK); key(K_ST);
        cyc(1'b0, 4'd0, 3'b000);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL run_before_rst got %b exp 1", bus.busy); end
        #2 rst = 1'b1;
        #1;
        e = pack(16, 16, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL async_rst got %h exp %h", snap(), e); end
        @(posedge clk);
        #1 rst = 1'b0;
        key(4'd5); key(K_OK);
        e = pack(5, 16, 16, 3'b000, 0, 0, 0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL after_rst got %h exp %h", snap(), e); end
    endtask

    task automatic test_random();
        logic [20:0] e;
        logic [3:0]  code;
        logic [2:0]  fl;
        bit          kv;
        int          r;
        int          runs = 0;
        rst = 1'b1;
        #3 rst = 1'b0;
        model_clear();
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      code = 4'($urandom_range(0, 9));
            else if (r < 80) code = K_OK;
            else if (r < 92) code = K_ST;
            else if (r < 95) code = K_CAN;
            else             code = 4'($urandom_range(12, 15));
            if (m_phase == 4) kv = ($urandom_range(0, 7) == 0);
            else              kv = ($urandom_range(0, 3) != 0);
            fl = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
            cyc(kv, code, fl);
            model_step(kv, code, fl);
            if (m_enter) runs++;
            e = model_out();
            checks++;
            if (snap() !== e) begin
                errors++;
                $display("FAIL random_cycle_%0d got %h exp %h", n, snap(), e);
            end
        end
        checks++;
        if (runs < 3) begin errors++; $display("FAIL random_runs got %0d exp >=3", runs); end
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.flag_R    = 1'b0;
        bus.flag_G    = 1'b0;
        bus.flag_B    = 1'b0;
        test_reset();
        test_dispense();
        test_digit_limits();
        test_ok_cancel();
        test_all_zero();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lector_rgb.md
LECTOR_RGB -- requirements
Module: lector_rgb

Interface
REQ-001 SHALL have parameter KEY_OK, default 4'hA, meaning confirm current color value.
REQ-002 SHALL have parameter KEY_CANCEL, default 4'hB, meaning discard entry and restart at R.
REQ-003 SHALL have parameter KEY_START, default 4'hE, meaning launch dispensing.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_valid  input  1  one-cycle strobe, key_code valid.
REQ-007 key_code  input  4  0-9 decimal digit, else command code.
REQ-008 flag_R, flag_G, flag_B  input  1 each  elapsed flags from the motor timer.
REQ-009 R, G, B  output  5 each  registered color amounts 0-15; 16 = not yet entered.
REQ-010 enter  output  1  one-cycle start pulse to the motor timer.
REQ-011 motor_R, motor_G, motor_B  output  1 each  motor enables, registered.
REQ-012 busy  output  1  high in RUN state.
REQ-013 err  output  1  one-cycle pulse on a rejected key.

Function
REQ-014 SHALL implement FSM states READ_R, READ_G, READ_B, READY, RUN, using a 5-bit accumulator acc and a 2-bit digit count ndig.
REQ-015 Digit key in READ_x: candidate = acc*10 + digit, computed at least 8 bits wide.
  - Candidate <= 15 and ndig < 2: acc <= candidate, ndig += 1.
  - Otherwise: key dropped, acc unchanged, err pulses.
REQ-016 KEY_OK in READ_x:
  - ndig = 0: err pulses, state unchanged.
  - Otherwise: the color output for x <= acc, acc <= 0, ndig <= 0, advance R->G->B->READY.
REQ-017 B SHALL hold 16 until KEY_OK is accepted in READ_B, so the consumer never latches partial values.
REQ-018 KEY_START in READY SHALL do all of the following in the next cycle:
  - Pulse enter for exactly one cycle.
  - Enter RUN.
  - Set motor_X = 1 for every color with value != 0.
REQ-019 In RUN, motor_X SHALL clear on the first rising edge where flag_X = 1.
  - Flags are ignored in the cycle enter is high and in all non-RUN states.
REQ-020 When all three motor enables are 0 in RUN, the block SHALL return to READ_R with R = G = B = 16.
  - This includes the case where all values are 0: RUN lasts one cycle.
REQ-021 KEY_CANCEL in any state except RUN SHALL:
  - Return to READ_R.
  - Set R = G = B = 16.
  - Clear acc and ndig.
REQ-022 All keys in RUN, and any key other than KEY_START or KEY_CANCEL in READY, SHALL raise err and otherwise be ignored.
REQ-023 Unassigned codes 0xC, 0xD, 0xF SHALL raise err in every non-RUN state.
REQ-024 Simultaneous flags SHALL clear their motors in the same cycle.
REQ-025 key_valid low SHALL cause no state change.

Reset
REQ-026 Asserting rst SHALL, at any time including mid-RUN:
  - Force state READ_R, acc = 0, ndig = 0.
  - Force R = G = B = 16.
  - Force enter = 0, motor_R/G/B = 0, busy = 0, err = 0.

Verification
REQ-027 Keys 1,2,OK,7,OK,1,5,OK,START -> R = 12, G = 7, B = 15; enter high one cycle; motors 111; busy = 1.
REQ-028 From REQ-027 run, pulse flag_G then flag_R, flag_B together -> motors 101 then 000; next cycle READ_R with R = G = B = 16.
REQ-029 Keys 2,OK,1,6 -> err on '6', acc stays 1; then 1,5 -> err on '5' (third digit), G stays 16.
REQ-030 Keys OK with no digit -> err, still READ_R; keys 3,OK,CANCEL -> R back to 16, READ_R.
REQ-031 Values 0,0,OK,0,OK,0,OK,START -> enter pulse, motors stay 000, busy for one cycle, back to READ_R.
REQ-032 rst asserted between clock edges mid-RUN -> outputs reset immediately (no clock edge needed), motors 000.
